golden_nonce_collector: RTL and testbench

- Sits directly downstream of the 256-bit hash/target comparator in the mining pipeline.
- Records every nonce as it is issued into the hash pipeline. Retires one recorded nonce per comparator result strobe, in order.
- Buffers the nonces whose hash met target ("golden nonces") for the host-interface reader via a valid/ready handshake.
- Also keeps hash and found counters plus sticky error flags.

---
 rtl/miner_pkg.sv | 18 +
 rtl/sync_fifo.sv | 68 ++++++
 rtl/golden_nonce_collector.sv | 121 ++++++++++++
 tb/tb_golden_nonce_collector.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/miner_pkg.sv
// Shared mining-pipeline types and elaboration-time helpers.
package miner_pkg;

  localparam int unsigned DEFAULT_NONCE_W = 32;

  typedef logic [DEFAULT_NONCE_W-1:0] nonce_t;

  // Ceiling log2, used to size FIFO pointers and occupancy counters.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with registered full/empty/count and sync clear.
// Push while full is accepted only when a pop happens in the same cycle.
module sync_fifo
  import miner_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CW-1:0]    count_nxt;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)      count_nxt = count + CW'(1);
    else if (do_pop && !do_push) count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage carries no reset; the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/golden_nonce_collector.sv
// Tracks in-flight nonces, retires them against comparator verdicts and
// buffers golden nonces for the host, with hash/found counters and sticky errors.
module golden_nonce_collector
  import miner_pkg::*;
#(
  parameter int unsigned NONCE_W   = DEFAULT_NONCE_W,
  parameter int unsigned TAG_DEPTH = 128,
  parameter int unsigned RES_DEPTH = 8,
  parameter int unsigned CNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               issue_valid,
  input  logic [NONCE_W-1:0] issue_nonce,
  input  logic               cmp_write,
  input  logic               cmp_out,
  output logic               res_valid,
  output logic [NONCE_W-1:0] res_nonce,
  input  logic               res_ready,
  output logic               tag_full,
  output logic [CNT_W-1:0]   hash_count,
  output logic [CNT_W-1:0]   found_count,
  output logic               err_tag_ovf,
  output logic               err_tag_unf,
  output logic               err_res_drop
);

  localparam int unsigned TAG_CW = clog2(TAG_DEPTH) + 1;
  localparam int unsigned RES_CW = clog2(RES_DEPTH) + 1;

  logic [NONCE_W-1:0] tag_head;
  logic               tag_empty;
  logic [TAG_CW-1:0]  tag_cnt;
  logic               res_full;
  logic               res_empty;
  logic [RES_CW-1:0]  res_cnt;

  logic               golden;
  logic               gold_valid;
  logic [NONCE_W-1:0] gold_nonce;
  logic               res_pop;
  logic               res_accept;
  logic               tag_ovf_evt;
  logic               tag_unf_evt;
  logic               res_drop_evt;
  logic               unused_cnt;

  sync_fifo #(
    .WIDTH (NONCE_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .push      (issue_valid),
    .push_data (issue_nonce),
    .pop       (cmp_write),
    .pop_data  (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_cnt)
  );

  sync_fifo #(
    .WIDTH (NONCE_W),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .push      (gold_valid),
    .push_data (gold_nonce),
    .pop       (res_ready),
    .pop_data  (res_nonce),
    .full      (res_full),
    .empty     (res_empty),
    .count     (res_cnt)
  );

  assign unused_cnt = ^{tag_cnt, res_cnt};

  // Retire decision; a full tag FIFO is never empty, so cmp_write always pops it.
  assign golden       = cmp_write & cmp_out & ~tag_empty;
  assign res_valid    = ~res_empty;
  assign res_pop      = res_valid & res_ready;
  assign res_accept   = gold_valid & (~res_full | res_pop);
  assign tag_ovf_evt  = issue_valid & tag_full & ~cmp_write;
  assign tag_unf_evt  = cmp_write & tag_empty;
  assign res_drop_evt = gold_valid & res_full & ~res_pop;

  // One-cycle golden stage between retire and the result FIFO push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gold_valid   <= 1'b0;
      gold_nonce   <= '0;
      hash_count   <= '0;
      found_count  <= '0;
      err_tag_ovf  <= 1'b0;
      err_tag_unf  <= 1'b0;
      err_res_drop <= 1'b0;
    end else if (clear) begin
      gold_valid   <= 1'b0;
      gold_nonce   <= '0;
      hash_count   <= '0;
      found_count  <= '0;
      err_tag_ovf  <= 1'b0;
      err_tag_unf  <= 1'b0;
      err_res_drop <= 1'b0;
    end else begin
      gold_valid <= golden;
      gold_nonce <= tag_head;
      if (cmp_write && (hash_count != '1))  hash_count  <= hash_count + CNT_W'(1);
      if (res_accept && (found_count != '1)) found_count <= found_count + CNT_W'(1);
      if (tag_ovf_evt)  err_tag_ovf  <= 1'b1;
      if (tag_unf_evt)  err_tag_unf  <= 1'b1;
      if (res_drop_evt) err_res_drop <= 1'b1;
    end
  end

endmodule

// File: tb/tb_golden_nonce_collector.sv
// Scoreboard bench for golden_nonce_collector: queue-based reference of both
// FIFOs, counters and flags, compared after every clock edge.
module tb_golden_nonce_collector;
  import miner_pkg::*;

  localparam int unsigned TAG_DEPTH = 128;
  localparam int unsigned RES_DEPTH = 8;
  localparam int unsigned CNT_W     = 32;

  logic             clk;
  logic             rst_n;
  logic             clear;
  logic             issue_valid;
  nonce_t           issue_nonce;
  logic             cmp_write;
  logic             cmp_out;
  logic             res_valid;
  nonce_t           res_nonce;
  logic             res_ready;
  logic             tag_full;
  logic [CNT_W-1:0] hash_count;
  logic [CNT_W-1:0] found_count;
  logic             err_tag_ovf;
  logic             err_tag_unf;
  logic             err_res_drop;

  golden_nonce_collector #(
    .NONCE_W   (DEFAULT_NONCE_W),
    .TAG_DEPTH (TAG_DEPTH),
    .RES_DEPTH (RES_DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .issue_valid  (issue_valid),
    .issue_nonce  (issue_nonce),
    .cmp_write    (cmp_write),
    .cmp_out      (cmp_out),
    .res_valid    (res_valid),
    .res_nonce    (res_nonce),
    .res_ready    (res_ready),
    .tag_full     (tag_full),
    .hash_count   (hash_count),
    .found_count  (found_count),
    .err_tag_ovf  (err_tag_ovf),
    .err_tag_unf  (err_tag_unf),
    .err_res_drop (err_res_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;
  int n_pops;
  nonce_t last_pop;

  // Reference state
  nonce_t           tag_q[$];
  nonce_t           res_q[$];
  logic             gp_v;
  nonce_t           gp_n;
  logic [CNT_W-1:0] m_hash;
  logic [CNT_W-1:0] m_found;
  logic             m_ovf;
  logic             m_unf;
  logic             m_drop;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    tag_q.delete();
    res_q.delete();
    gp_v    = 1'b0;
    gp_n    = '0;
    m_hash  = '0;
    m_found = '0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_drop  = 1'b0;
  endtask

  task automatic check_outputs();
    check_eq("res_valid", 64'(res_valid), 64'(res_q.size() != 0));
    if (res_q.size() != 0) check_eq("res_nonce_head", 64'(res_nonce), 64'(res_q[0]));
    check_eq("tag_full", 64'(tag_full), 64'(tag_q.size() == int'(TAG_DEPTH)));
    check_eq("hash_count", 64'(hash_count), 64'(m_hash));
    check_eq("found_count", 64'(found_count), 64'(m_found));
    check_eq("err_tag_ovf", 64'(err_tag_ovf), 64'(m_ovf));
    check_eq("err_tag_unf", 64'(err_tag_unf), 64'(m_unf));
    check_eq("err_res_drop", 64'(err_res_drop), 64'(m_drop));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".res_valid"}, 64'(res_valid), 64'd0);
    check_eq({tag, ".res_nonce"}, 64'(res_nonce), 64'd0);
    check_eq({tag, ".tag_full"}, 64'(tag_full), 64'd0);
    check_eq({tag, ".hash_count"}, 64'(hash_count), 64'd0);
    check_eq({tag, ".found_count"}, 64'(found_count), 64'd0);
    check_eq({tag, ".errs"}, 64'({err_tag_ovf, err_tag_unf, err_res_drop}), 64'd0);
  endtask

  // One clock: drive at negedge, score any handshake, then update reference after the edge.
  task automatic step(input logic iv, input nonce_t n, input logic cw, input logic co,
                      input logic rr, input logic clr);
    logic   pop_m;
    logic   golden_new;
    nonce_t popped;
    nonce_t tmp;
    @(negedge clk);
    issue_valid = iv;
    issue_nonce = n;
    cmp_write   = cw;
    cmp_out     = co;
    res_ready   = rr;
    clear       = clr;
    pop_m = !clr && rr && (res_q.size() != 0);
    if (pop_m) begin
      check_eq("res_valid_at_pop", 64'(res_valid), 64'd1);
      check_eq("res_nonce_popped", 64'(res_nonce), 64'(res_q[0]));
      last_pop = res_nonce;
      n_pops++;
    end
    @(posedge clk);
    #1;
    if (clr) begin
      model_reset();
    end else begin
      if (pop_m) tmp = res_q.pop_front();
      if (gp_v) begin
        if (res_q.size() < int'(RES_DEPTH)) begin
          res_q.push_back(gp_n);
          if (m_found != '1) m_found = m_found + 1;
        end else begin
          m_drop = 1'b1;
        end
      end
      golden_new = 1'b0;
      popped     = '0;
      if (cw) begin
        if (m_hash != '1) m_hash = m_hash + 1;
        if (tag_q.size() == 0) m_unf = 1'b1;
        else begin
          popped     = tag_q.pop_front();
          golden_new = co;
        end
      end
      if (iv) begin
        if (tag_q.size() < int'(TAG_DEPTH)) tag_q.push_back(n);
        else m_ovf = 1'b1;
      end
      gp_v = golden_new;
      gp_n = popped;
    end
    check_outputs();
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, rr, 1'b0);
  endtask

  task automatic issue_seq(input nonce_t base, input int n, input logic rr);
    for (int i = 0; i < n; i++) step(1'b1, base + nonce_t'(i), 1'b0, 1'b0, rr, 1'b0);
  endtask

  task automatic strobe(input logic co, input logic rr);
    step(1'b0, '0, 1'b1, co, rr, 1'b0);
  endtask

  task automatic do_clear();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; n_pops = 0; last_pop = '1;
    rst_n = 1'b0; clear = 1'b0; issue_valid = 1'b0; issue_nonce = '0;
    cmp_write = 1'b0; cmp_out = 1'b0; res_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Ten nonces in flight, only the fourth is golden
    issue_seq(32'h0000_0000, 10, 1'b1);
    idle(30, 1'b1);
    for (int i = 0; i < 10; i++) strobe(i == 3, 1'b1);
    idle(3, 1'b1);
    check_eq("basic.hash", 64'(hash_count), 64'd10);
    check_eq("basic.found", 64'(found_count), 64'd1);
    check_eq("basic.pops", 64'(n_pops), 64'd1);
    check_eq("basic.nonce", 64'(last_pop), 64'h3);

    // Back-pressure: ninth golden result is dropped
    do_clear();
    issue_seq(32'h0000_0100, 9, 1'b0);
    for (int i = 0; i < 9; i++) strobe(1'b1, 1'b0);
    idle(2, 1'b0);
    check_eq("bp.found", 64'(found_count), 64'd8);
    check_eq("bp.drop", 64'(err_res_drop), 64'd1);
    n_pops = 0;
    idle(10, 1'b1);
    check_eq("bp.pops", 64'(n_pops), 64'd8);
    check_eq("bp.last", 64'(last_pop), 64'h107);

    // Result FIFO full, push and pop on the same edge
    do_clear();
    issue_seq(32'h0000_0200, 9, 1'b0);
    for (int i = 0; i < 8; i++) strobe(1'b1, 1'b0);
    idle(2, 1'b0);
    strobe(1'b1, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);
    check_eq("simul.drop", 64'(err_res_drop), 64'd0);
    check_eq("simul.found", 64'(found_count), 64'd9);
    n_pops = 0;
    idle(10, 1'b1);
    check_eq("simul.pops", 64'(n_pops), 64'd8);
    check_eq("simul.last", 64'(last_pop), 64'h208);

    // In-flight FIFO full boundary
    do_clear();
    issue_seq(32'h0000_1000, 128, 1'b1);
    check_eq("full.tag_full", 64'(tag_full), 64'd1);
    step(1'b1, 32'h0000_AAAA, 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("full.pushpop_ovf", 64'(err_tag_ovf), 64'd0);
    check_eq("full.pushpop_full", 64'(tag_full), 64'd1);
    step(1'b1, 32'h0000_BBBB, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("full.ovf", 64'(err_tag_ovf), 64'd1);
    for (int i = 0; i < 128; i++) strobe(i == 127, 1'b1);
    idle(3, 1'b1);
    check_eq("full.last", 64'(last_pop), 64'hAAAA);

    // Underflow, then empty with simultaneous push and pop
    do_clear();
    strobe(1'b1, 1'b1);
    idle(3, 1'b1);
    check_eq("unf.flag", 64'(err_tag_unf), 64'd1);
    check_eq("unf.res_valid", 64'(res_valid), 64'd0);
    check_eq("unf.hash", 64'(hash_count), 64'd1);
    do_clear();
    step(1'b1, 32'h0000_5555, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);
    check_eq("unf2.flag", 64'(err_tag_unf), 64'd1);
    check_eq("unf2.found", 64'(found_count), 64'd0);
    strobe(1'b1, 1'b1);
    idle(3, 1'b1);
    check_eq("unf2.last", 64'(last_pop), 64'h5555);
    check_eq("unf2.found_after", 64'(found_count), 64'd1);

    // Mid-operation asynchronous reset
    do_clear();
    issue_seq(32'h0000_3000, 64, 1'b0);
    for (int i = 0; i < 4; i++) strobe(1'b1, 1'b0);
    idle(2, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Mid-operation synchronous clear, with an issue on the same cycle
    issue_seq(32'h0000_4000, 64, 1'b0);
    for (int i = 0; i < 4; i++) strobe(1'b1, 1'b0);
    idle(2, 1'b0);
    step(1'b1, 32'h0000_9999, 1'b1, 1'b1, 1'b1, 1'b1);
    check_all_zero("sync_clear");
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b0);
    strobe(1'b1, 1'b1);
    idle(3, 1'b1);
    check_eq("post_clear.nonce", 64'(last_pop), 64'hDEAD_BEEF);
    check_eq("post_clear.found", 64'(found_count), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
